mod997_reduce_seq: RTL and testbench

Sequential modular reducer for the mod-997 multiplier datapath: consumes a wide integer (typically the recombined sum of 3x3 partial-product digits) and returns its residue and quotient modulo 997. Uses restoring long division, one input bit per clock, behind valid/ready handshakes on both sides. Sits downstream of the combinational digit-multiplier array, so its output feeds the next residue-domain stage.

---
 rtl/mod997_reduce_seq_if.sv | 36 +++
 rtl/mod997_reduce_seq.sv | 91 +++++++++
 tb/tb_mod997_reduce_seq.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod997_reduce_seq_if.sv
// Operand/result bus for the mod-997 sequential reducer.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// the producer holds valid and data until it sees ready, and the consumer holds off
// the transfer by keeping ready low for as long as it needs to.
interface mod997_reduce_seq_if #(
    parameter int IN_W = 20,
    parameter int R_W  = 10
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [R_W-1:0]  out_rem;
    logic [IN_W-1:0] out_quo;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_rem,
        input  out_quo
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_rem,
        output out_quo
    );
endinterface

// File: rtl/mod997_reduce_seq.sv
// Restoring long-division reducer: one operand bit per clock, producing P mod MOD
// and floor(P / MOD). The FSM state is exported on dbg_state.
module mod997_reduce_seq #(
    parameter int IN_W = 20,
    parameter int MOD  = 997,
    parameter int R_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod997_reduce_seq_if.slave   bus,
    output logic [1:0]           dbg_state
);
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [R_W:0]   MOD_R = (R_W + 1)'(MOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [IN_W-1:0]  sreg;
    logic [R_W:0]     r;
    logic [IN_W-1:0]  q;
    logic [CNT_W-1:0] cnt;

    logic [R_W:0]     t;
    logic             qbit;
    logic             in_ready_c;
    logic             out_valid_c;

    // r < MOD < 2^R_W, so its top bit is always 0 and 2r + bit fits in R_W+1 bits.
    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        t           = {r[R_W-1:0], sreg[IN_W-1]};
        qbit        = (t >= MOD_R);
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg <= bus.in_data;
                        r    <= '0;
                        q    <= '0;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    r    <= qbit ? (t - MOD_R) : t;
                    q    <= {q[IN_W-2:0], qbit};
                    sreg <= {sreg[IN_W-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_rem   = r[R_W-1:0];
    assign bus.out_quo   = q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_mod997_reduce_seq.sv
// Directed and randomised bench for mod997_reduce_seq with an expected-result queue.
module tb_mod997_reduce_seq;
    localparam int IN_W = 20;
    localparam int R_W  = 10;
    localparam int MOD  = 997;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IN_W+R_W-1:0] exp_q[$];

    mod997_reduce_seq_if #(.IN_W(IN_W), .R_W(R_W)) bus ();

    mod997_reduce_seq #(.IN_W(IN_W), .MOD(MOD), .R_W(R_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] p, input bit hold_valid, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = p;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!hold_valid) bus.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never seen for operand %0d", p);
        end
    endtask

    task automatic wait_valid(input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < bound) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: out_valid not seen within %0d cycles", bound);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit ok;
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_rem, bus.out_quo, dbg_state} !==
            {1'b1, 1'b0, 10'd0, 20'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: rdy=%b vld=%b rem=%0d quo=%0d st=%0d, want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_rem, bus.out_quo, dbg_state);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_rem, bus.out_quo} !== {1'b1, 1'b0, 10'd0, 20'd0}) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b vld=%b rem=%0d quo=%0d, want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_rem, bus.out_quo);
        end
        // abort a division part way through
        send(20'd992016, 1'b0, ok);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_rem, bus.out_quo, dbg_state} !==
            {1'b1, 1'b0, 10'd0, 20'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_busy: rdy=%b vld=%b rem=%0d quo=%0d st=%0d, want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_rem, bus.out_quo, dbg_state);
        end
        #2 rst_n = 1'b1;
        tick();
        // 4988 = 5*997 + 3
        send(20'd4988, 1'b0, ok);
        wait_valid(40, n, ok);
        n_checks++;
        if (bus.out_rem !== 10'd3 || bus.out_quo !== 20'd5) begin
            n_fail++;
            $display("FAIL after_reset_op: rem=%0d quo=%0d, want 3 5", bus.out_rem, bus.out_quo);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_max_residue();
        bit ok;
        int n;
        send(20'd992016, 1'b0, ok);
        wait_valid(40, n, ok);
        n_checks++;
        if (n !== 20) begin
            n_fail++;
            $display("FAIL max_latency: out_valid after %0d cycles, want 20", n);
        end
        n_checks++;
        if (bus.out_rem !== 10'd1 || bus.out_quo !== 20'd995) begin
            n_fail++;
            $display("FAIL max_result: rem=%0d quo=%0d, want 1 995", bus.out_rem, bus.out_quo);
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL max_release: vld=%b rdy=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0] p_v[4]   = '{20'd0, 20'd996, 20'd997, 20'd1048575};
        logic [R_W-1:0]  rem_v[4] = '{10'd0, 10'd996, 10'd0, 10'd728};
        logic [IN_W-1:0] quo_v[4] = '{20'd0, 20'd0, 20'd1, 20'd1051};
        bit ok;
        int n;
        int spacing;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(p_v[i], 1'b0, ok);
            wait_valid(40, n, ok);
            n_checks++;
            if (bus.out_rem !== rem_v[i] || bus.out_quo !== quo_v[i]) begin
                n_fail++;
                $display("FAIL boundary_%0d: P=%0d rem=%0d quo=%0d, want %0d %0d",
                         i, p_v[i], bus.out_rem, bus.out_quo, rem_v[i], quo_v[i]);
            end
            // time from this result to the next accept edge completes the spacing
            if (i < 3) begin
                spacing = n;
                bus.in_valid = 1'b1;
                bus.in_data  = p_v[i+1];
                while (!bus.in_ready && spacing < 60) begin
                    tick();
                    spacing++;
                end
                spacing++;
                n_checks++;
                if (spacing !== 22) begin
                    n_fail++;
                    $display("FAIL accept_spacing_%0d: %0d cycles, want 22", i, spacing);
                end
            end
        end
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        int bad;
        bus.out_ready = 1'b0;
        send(20'd123456, 1'b0, ok);
        wait_valid(40, n, ok);
        bus.in_valid = 1'b1;
        bus.in_data  = 20'd7;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_rem !== 10'd825 || bus.out_quo !== 20'd123) begin
                n_fail++;
                bad++;
                if (bad < 4)
                    $display("FAIL backpressure_hold: cyc %0d vld=%b rdy=%b rem=%0d quo=%0d, want 1 0 825 123",
                             i, bus.out_valid, bus.in_ready, bus.out_rem, bus.out_quo);
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: rdy=%b vld=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_input_protocol();
        bit ok;
        int n;
        int extra;
        // 500000 = 501*997 + 503
        send(20'd500000, 1'b1, ok);
        extra = 0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            bus.in_data = IN_W'($urandom_range(0, 20'hFFFFF));
            if (bus.in_ready) extra++;
            tick();
            n++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL protocol_no_accept: in_ready seen %0d times in BUSY, want 0", extra);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rem !== 10'd503 || bus.out_quo !== 20'd501) begin
            n_fail++;
            $display("FAIL protocol_result: vld=%b rem=%0d quo=%0d, want 1 503 501",
                     bus.out_valid, bus.out_rem, bus.out_quo);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        bit rdy_early;
        int n;
        int pi;
        logic [IN_W+R_W-1:0] exp;
        logic [IN_W+R_W-1:0] got;
        for (int k = 0; k < 1500; k++) begin
            pi = int'($urandom_range(0, 20'hFFFFF));
            exp_q.push_back({IN_W'(pi / MOD), R_W'(pi % MOD)});
            repeat ($urandom_range(0, 2)) tick();
            rdy_early = 1'($urandom_range(0, 1));
            bus.out_ready = rdy_early;
            send(IN_W'(pi), 1'b0, ok);
            wait_valid(40, n, ok);
            if (!ok) continue;
            got = {bus.out_quo, bus.out_rem};
            if (!rdy_early) begin
                repeat ($urandom_range(0, 4)) tick();
                bus.out_ready = 1'b1;
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL random_dup: result quo=%0d rem=%0d with nothing expected",
                         got[IN_W+R_W-1:R_W], got[R_W-1:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp || {bus.out_quo, bus.out_rem} !== exp) begin
                    n_fail++;
                    $display("FAIL random_%0d: P=%0d quo=%0d rem=%0d, want %0d %0d", k, pi,
                             bus.out_quo, bus.out_rem, exp[IN_W+R_W-1:R_W], exp[R_W-1:0]);
                end
            end
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL random_release_%0d: out_valid=%b after handshake, want 0", k, bus.out_valid);
            end
            bus.out_ready = 1'b0;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drops: %0d results never produced, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_max_residue();
        test_back_to_back();
        test_backpressure();
        test_input_protocol();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
